// File: rtl/gaplus_starctl.sv
// Starfield control: CPU-written shadow registers, committed to the generator once per
// frame on the VB falling edge, with optional per-layer speed ramping.
module gaplus_starctl #(
  parameter int RAMP_FRAMES = 4
) (
  input  logic       VCLK,
  input  logic       RESET,
  input  logic       WE,
  input  logic [1:0] AD,
  input  logic [7:0] DI,
  input  logic       VB,
  output logic [4:0] C1,
  output logic [4:0] C2,
  output logic [4:0] C3,
  output logic       STAR_EN,
  output logic [7:0] FRAME,
  output logic       BUSY
);

  localparam logic [3:0] RF_LAST = (RAMP_FRAMES == 0) ? 4'd0 : 4'(RAMP_FRAMES - 1);

  logic [4:0] s1, s2, s3;
  logic [4:0] t1, t2, t3;
  logic [1:0] ctl;
  logic [3:0] rcnt;
  logic       vb_d;

  logic       commit;
  logic       bypass;
  logic       step_now;
  logic [4:0] c1_n, c2_n, c3_n;
  logic       busy_n;
  logic [3:0] rcnt_n;

  // One unit of movement toward the target: a change of [4:3] must pass through magnitude 0.
  function automatic logic [4:0] ramp_step(input logic [4:0] a, input logic [4:0] t);
    logic [4:0] r;
    r = a;
    if (a != t) begin
      if (a[4:3] == t[4:3]) begin
        if (a[2:0] < t[2:0]) r[2:0] = a[2:0] + 3'd1;
        else                 r[2:0] = a[2:0] - 3'd1;
      end else if (a[2:0] != 3'd0) begin
        r[2:0] = a[2:0] - 3'd1;
      end else begin
        r[4:3] = t[4:3];
      end
    end
    return r;
  endfunction

  always_comb begin
    commit   = vb_d && !VB;
    bypass   = ctl[1] || (RAMP_FRAMES == 0);
    step_now = (rcnt == RF_LAST);
    c1_n     = C1;
    c2_n     = C2;
    c3_n     = C3;
    if (bypass) begin
      c1_n = s1;
      c2_n = s2;
      c3_n = s3;
    end else if (step_now) begin
      c1_n = ramp_step(C1, s1);
      c2_n = ramp_step(C2, s2);
      c3_n = ramp_step(C3, s3);
    end
    busy_n = (c1_n != s1) || (c2_n != s2) || (c3_n != s3);
    // Idle keeps the counter parked so a fresh change gets a full interval.
    if (bypass || !busy_n || step_now) rcnt_n = 4'd0;
    else                               rcnt_n = rcnt + 4'd1;
  end

  always_ff @(posedge VCLK) begin
    if (RESET) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      ctl     <= '0;
      t1      <= '0;
      t2      <= '0;
      t3      <= '0;
      C1      <= '0;
      C2      <= '0;
      C3      <= '0;
      STAR_EN <= 1'b0;
      FRAME   <= '0;
      BUSY    <= 1'b0;
      rcnt    <= '0;
      vb_d    <= 1'b0;
    end else begin
      vb_d <= VB;
      if (WE) begin
        case (AD)
          2'd0:    s1  <= DI[4:0];
          2'd1:    s2  <= DI[4:0];
          2'd2:    s3  <= DI[4:0];
          default: ctl <= DI[1:0];
        endcase
      end
      // Shadows are read before this edge's write lands, so a same-cycle write waits a frame.
      if (commit) begin
        FRAME   <= FRAME + 8'd1;
        STAR_EN <= ctl[0];
        t1      <= s1;
        t2      <= s2;
        t3      <= s3;
        C1      <= c1_n;
        C2      <= c2_n;
        C3      <= c3_n;
        BUSY    <= busy_n;
        rcnt    <= rcnt_n;
      end
    end
  end

endmodule

// File: tb/tb_gaplus_starctl.sv
// Bench for gaplus_starctl: four instances (RAMP_FRAMES 4/2/1/0) on shared stimulus,
// checked against a frame-level reference model plus directed expectations.
module tb_gaplus_starctl;

  logic       VCLK = 1'b0;
  logic       RESET, WE, VB;
  logic [1:0] AD;
  logic [7:0] DI;

  always #5 VCLK = ~VCLK;

  int rfv [4] = '{4, 2, 1, 0};

  logic [4:0]  c1_o [4];
  logic [4:0]  c2_o [4];
  logic [4:0]  c3_o [4];
  logic        en_o [4];
  logic [7:0]  fr_o [4];
  logic        bz_o [4];
  logic [24:0] obs  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    gaplus_starctl #(.RAMP_FRAMES((g == 0) ? 4 : 3 - g)) u_dut (
      .VCLK(VCLK), .RESET(RESET), .WE(WE), .AD(AD), .DI(DI), .VB(VB),
      .C1(c1_o[g]), .C2(c2_o[g]), .C3(c3_o[g]),
      .STAR_EN(en_o[g]), .FRAME(fr_o[g]), .BUSY(bz_o[g])
    );
    assign obs[g] = {c1_o[g], c2_o[g], c3_o[g], en_o[g], fr_o[g], bz_o[g]};
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model, evaluated once per VCLK edge at frame granularity.
  logic [4:0] m_sh [3];
  logic [1:0] m_ctl;
  logic [4:0] m_tg [3];
  logic       m_vbd, m_sten;
  logic [7:0] m_frame;
  logic [4:0] m_act [4][3];
  logic       m_busy [4];
  int         m_ph [4];

  function automatic logic [4:0] m_step(input logic [4:0] a, input logic [4:0] t);
    int am, tm;
    am = int'(a[2:0]);
    tm = int'(t[2:0]);
    if (a == t) return a;
    if (a[4:3] != t[4:3]) return (am > 0) ? {a[4:3], 3'(am - 1)} : {t[4:3], 3'd0};
    return {a[4:3], 3'((tm > am) ? am + 1 : am - 1)};
  endfunction

  function automatic void model_clock();
    if (RESET) begin
      for (int i = 0; i < 3; i++) begin m_sh[i] = '0; m_tg[i] = '0; end
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 3; i++) m_act[k][i] = '0;
        m_busy[k] = 1'b0;
        m_ph[k] = 0;
      end
      m_ctl = '0; m_vbd = 1'b0; m_sten = 1'b0; m_frame = '0;
      return;
    end
    if (m_vbd && !VB) begin
      m_frame = m_frame + 8'd1;
      m_sten  = m_ctl[0];
      for (int i = 0; i < 3; i++) m_tg[i] = m_sh[i];
      for (int k = 0; k < 4; k++) begin
        if (m_ctl[1] || rfv[k] == 0) begin
          for (int i = 0; i < 3; i++) m_act[k][i] = m_tg[i];
        end else begin
          m_ph[k]++;
          if (m_ph[k] % rfv[k] == 0)
            for (int i = 0; i < 3; i++) m_act[k][i] = m_step(m_act[k][i], m_tg[i]);
        end
        m_busy[k] = 1'b0;
        for (int i = 0; i < 3; i++) if (m_act[k][i] != m_tg[i]) m_busy[k] = 1'b1;
        if (!m_busy[k]) m_ph[k] = 0;
      end
    end
    if (WE) begin
      if (AD == 2'd3) m_ctl = DI[1:0];
      else            m_sh[AD] = DI[4:0];
    end
    m_vbd = VB;
  endfunction

  function automatic logic [24:0] exp_vec(input int k);
    return {m_act[k][0], m_act[k][1], m_act[k][2], m_sten, m_frame, m_busy[k]};
  endfunction

  task automatic step(input logic rst, input logic we, input logic [1:0] ad,
                      input logic [7:0] di, input logic vb);
    RESET = rst; WE = we; AD = ad; DI = di; VB = vb;
    @(posedge VCLK);
    model_clock();
    #1;
  endtask

  task automatic wr(input logic [1:0] ad, input logic [7:0] di);
    step(1'b0, 1'b1, ad, di, 1'b0);
  endtask

  task automatic frame();
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 2'd0, 8'h00, c < 2);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'hFF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs[k] !== 25'd0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d got %h exp %h", k, obs[k], 25'd0);
      end
    end
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b0, 1'b0, 2'd0, 8'h00, c < 2);
        for (int k = 0; k < 4; k++) begin
          vectors++;
          if (obs[k] !== exp_vec(k)) begin
            miscompares++;
            $display("FAIL idle_model dut%0d got %h exp %h", k, obs[k], exp_vec(k));
          end
        end
      end
    end
    vectors++;
    if (fr_o[0] !== 8'd3 || c1_o[0] !== 5'd0 || en_o[0] !== 1'b0 || bz_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_3_frames got frame=%0d c1=%h en=%b busy=%b exp frame=3 c1=00 en=0 busy=0",
               fr_o[0], c1_o[0], en_o[0], bz_o[0]);
    end
  endtask

  task automatic test_bypass();
    wr(2'd3, 8'h03);
    wr(2'd0, 8'h15);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
      vectors++;
      if (c1_o[0] !== 5'h00 || en_o[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL bypass_vb_high got c1=%h en=%b exp c1=00 en=0", c1_o[0], en_o[0]);
      end
    end
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (c1_o[k] !== 5'h15 || en_o[k] !== 1'b1 || bz_o[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL bypass_commit dut%0d got c1=%h en=%b busy=%b exp c1=15 en=1 busy=0",
                 k, c1_o[k], en_o[k], bz_o[k]);
      end
    end
  endtask

  task automatic test_ramp();
    wr(2'd0, 8'h00);
    frame();
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h05);
    for (int f = 1; f <= 12; f++) begin
      frame();
      vectors++;
      if (c1_o[1] !== 5'((f / 2 > 5) ? 5 : f / 2) || bz_o[1] !== (f < 10)) begin
        miscompares++;
        $display("FAIL ramp_rf2 frame %0d got c1=%h busy=%b exp c1=%h busy=%b", f, c1_o[1],
                 bz_o[1], 5'((f / 2 > 5) ? 5 : f / 2), (f < 10));
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL ramp_model dut%0d got %h exp %h", k, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_reversal();
    logic [4:0] exp_c2 [7] = '{5'h02, 5'h01, 5'h00, 5'h08, 5'h09, 5'h0A, 5'h0B};
    wr(2'd3, 8'h03);
    wr(2'd1, 8'h03);
    frame();
    wr(2'd3, 8'h01);
    wr(2'd1, 8'h0B);
    for (int f = 0; f < 8; f++) begin
      frame();
      vectors++;
      if (c2_o[2] !== exp_c2[(f < 7) ? f : 6]) begin
        miscompares++;
        $display("FAIL reversal_rf1 frame %0d got c2=%h exp %h", f + 1, c2_o[2],
                 exp_c2[(f < 7) ? f : 6]);
      end
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL reversal_model dut%0d got %h exp %h", k, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_commit_write();
    wr(2'd3, 8'h03);
    frame();
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 2'd1, 8'h07, 1'b0);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (c2_o[k] !== 5'h0B) begin
        miscompares++;
        $display("FAIL commit_cycle_write dut%0d got c2=%h exp 0b", k, c2_o[k]);
      end
    end
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    frame();
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (c2_o[k] !== 5'h07 || obs[k] !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL commit_next_frame dut%0d got c2=%h obs=%h exp c2=07 obs=%h",
                 k, c2_o[k], obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_reset_midramp();
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h17);
    frame();
    frame();
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 2'd2, 8'h1F, 1'b1);
    step(1'b1, 1'b1, 2'd0, 8'h1F, 1'b1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (obs[k] !== 25'd0) begin
        miscompares++;
        $display("FAIL reset_midramp dut%0d got %h exp %h", k, obs[k], 25'd0);
      end
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
      vectors++;
      if (fr_o[0] !== 8'd0) begin
        miscompares++;
        $display("FAIL no_commit_after_reset got frame=%0d exp 0", fr_o[0]);
      end
    end
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    vectors++;
    if (fr_o[0] !== 8'd1 || c1_o[0] !== 5'd0) begin
      miscompares++;
      $display("FAIL first_fall_after_reset got frame=%0d c1=%h exp frame=1 c1=00", fr_o[0], c1_o[0]);
    end
  endtask

  task automatic test_frame_wrap();
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    for (int f = 0; f < 256; f++) begin
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
      if (f == 254) begin
        vectors++;
        if (fr_o[0] !== 8'd255) begin
          miscompares++;
          $display("FAIL frame_255 got %0d exp 255", fr_o[0]);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (fr_o[k] !== 8'd0 || obs[k] !== exp_vec(k)) begin
        miscompares++;
        $display("FAIL frame_wrap dut%0d got frame=%0d exp 0", k, fr_o[k]);
      end
    end
  endtask

  task automatic test_random();
    int vb_left;
    logic vb;
    vb = 1'b0;
    vb_left = 3;
    for (int n = 0; n < 4000; n++) begin
      if (vb_left == 0) begin
        vb = ~vb;
        vb_left = vb ? $urandom_range(1, 4) : $urandom_range(1, 8);
      end
      vb_left--;
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 9) < 3),
           2'($urandom_range(0, 3)), 8'($urandom), vb);
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (obs[k] !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL random_model cycle %0d dut%0d got %h exp %h", n, k, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    RESET = 1'b1; WE = 1'b0; AD = 2'd0; DI = 8'h00; VB = 1'b0;
    test_reset();
    test_bypass();
    test_ramp();
    test_reversal();
    test_commit_write();
    test_reset_midramp();
    test_frame_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gaplus_starctl.md
Name: gaplus_starctl

Overview:
- CPU-facing control block for the three-layer starfield generator.
- Captures CPU writes to the star control registers into shadow registers, then commits them to the generator's C1/C2/C3 inputs once per frame, at the VB falling edge. The generator samples C1..C3 at VB rise, so its inputs are stable for a whole active period before each sample.
- Optionally ramps each layer's speed one step per N frames so speed and direction changes are smooth.
- Sits between the main CPU bus decode and the starfield generator.

Parameters:
- RAMP_FRAMES, 4: number of frames per one-unit speed step during ramping (1..15). 0 means immediate commit.

Ports:
- VCLK  in  1  pixel clock
- RESET  in  1  synchronous active-high reset
- WE  in  1  CPU write strobe, one VCLK pulse per access
- AD  in  2  register select: 0/1/2 = layer 1/2/3 speed, 3 = control
- DI  in  8  CPU write data; bits [4:0] used for layers, bits [1:0] for control
- VB  in  1  vertical blank, level
- C1  out  5  layer 1 speed to generator: [4]=x384, [3]=dir, [2:0]=magnitude
- C2  out  5  layer 2 speed, same format
- C3  out  5  layer 3 speed, same format
- STAR_EN  out  1  starfield output enable, for the mixer
- FRAME  out  8  committed-frame counter
- BUSY  out  1  high while any layer's active value differs from its target

Behaviour:
- Reset values:
  - shadow S1..S3 = 0, control shadow = 2'b00, targets T1..T3 = 0.
  - C1..C3 = 0, STAR_EN = 0, FRAME = 0, BUSY = 0, ramp counter = 0, vb_d = 0.
  - Reset is synchronous and overrides everything, including mid-ramp and mid-write.
- Writes:
  - WE=1 stores DI into the shadow selected by AD on that VCLK edge.
  - Writes are accepted regardless of VB or ramp state. Last write before commit wins.
- Commit event:
  - vb_d is VB registered each cycle. Commit fires in the cycle where vb_d=1 and VB=0 (VB falling edge).
  - A write in the commit cycle lands in the shadow but is not committed; the pre-write shadow value is used, and the new value is committed next frame.
- On commit:
  - FRAME <= FRAME+1, wrapping 255->0.
  - STAR_EN <= ctl[0].
  - T1..T3 <= S1..S3.
- Ramp evaluation per layer, performed on every commit after the targets are captured. "Active" is the layer's current Cn; "target" is Tn.
  - Bypass: if ctl[1]=1 (bypass) or RAMP_FRAMES=0, active <= target immediately.
  - Otherwise the ramp counter decides. It is shared by all three layers and counts commits 0..RAMP_FRAMES-1.
  - A step occurs only on the commit where the counter equals RAMP_FRAMES-1; the counter then wraps to 0. On other commits it just increments.
  - On a step, each layer with active != target takes one of these actions:
    - Same [4:3] bits: magnitude moves 1 toward target magnitude.
    - Different [4:3] bits, active magnitude > 0: magnitude decrements by 1 with [4:3] held.
    - Different [4:3] bits, active magnitude = 0: adopt target [4:3] in this step, magnitude stays 0.
  - Layers already equal to their target are unchanged.
- BUSY:
  - Registered. Updated on each commit to (C1!=T1)|(C2!=T2)|(C3!=T3), evaluated with the post-commit values.
  - While BUSY=0, the ramp counter is held at 0, so a new change starts a full RAMP_FRAMES interval from its first commit.
- Stability:
  - C1..C3, STAR_EN, FRAME and BUSY change only in the commit cycle, or on reset.
  - They are constant through all VB=1 cycles.
- VB edge cases:
  - VB held high indefinitely: no commits occur.
  - VB already high when reset deasserts: the first fall commits normally.
  - Glitch of one cycle high then low: treated as a full frame and commits.
- Widths: magnitude arithmetic is 3-bit unsigned and never wraps; steps stop at the target. FRAME is 8-bit modulo.

Test Plan:
- Reset then idle three frames -> C1..C3=0, STAR_EN=0, FRAME=3, BUSY=0.
- Write AD=3 DI=0x03 (enable, bypass), AD=0 DI=0x15, then toggle VB high/low -> after the fall C1=0x15, STAR_EN=1, BUSY=0, with no change while VB=1.
- Ramp, RAMP_FRAMES=2, no bypass, C1=0, write S1=0x05:
  - C1 steps 1 at frame 2, 2 at frame 4, ... 5 at frame 10.
  - BUSY=1 from frame 1 until the commit that reaches 0x05.
- Direction reversal, RAMP_FRAMES=1, C2=0x03, write S2=0x0B:
  - Per frame C2 = 0x02, 0x01, 0x00, 0x08, 0x09, 0x0A, 0x0B.
- Write AD=1 DI=0x07 in the exact commit cycle -> C2 unchanged that frame; commits 0x07 at the next VB fall (bypass on).
- Assert RESET mid-ramp while VB=1 -> next cycle all outputs are at reset values; no commit until a fresh VB fall. Separately, run 256 frames -> FRAME wraps to 0.
